// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: fetch stage ahead of the instruction-interface wrapper.
// Issues one request at a time, collects responses into a small FIFO of
// {pc, inst} pairs for decode, and squashes in-flight responses on redirect.
// Optional build macro: FETCH_PERF_CNT_EN adds three 32-bit perf counters.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        cpu_clk,
  input  logic                        cpu_reset,
  output logic [31:0]                 PC,
  output logic                        Inst_Req_Valid,
  input  logic                        Inst_Req_Ready,
  input  logic [31:0]                 Instruction,
  input  logic                        Inst_Valid,
  output logic                        Inst_Ready,
  input  logic                        redirect_valid,
  input  logic [31:0]                 redirect_pc,
  output logic                        if_valid,
  output logic [31:0]                 if_pc,
  output logic [31:0]                 if_inst,
  input  logic                        if_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                 perf_inst_cnt,
  output logic [31:0]                 perf_stall_cnt,
  output logic [31:0]                 perf_flush_cnt
`endif
);

  localparam int unsigned      PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned      CNT_W      = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_M1_C = CNT_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_RESP  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      req_addr_q, req_addr_d;
  logic             squash_q, squash_d;
  logic             req_valid_q;
  logic             resp_ready_q;

  logic [63:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q, count_d;

  logic             push_s;
  logic             pop_s;
  logic             flush_s;
  logic             room_after_push_s;
  logic [31:0]      redirect_tgt_s;
  logic [63:0]      head_s;

  // A redirect flushes the buffer in the same cycle; flush beats push and pop.
  assign flush_s           = redirect_valid;
  assign redirect_tgt_s    = redirect_pc & 32'hFFFF_FFFC;
  assign pop_s             = (count_q != CNT_W'(0)) && if_ready;
  // After this cycle's push (and possible pop) is there still a free slot to reserve?
  assign room_after_push_s = pop_s || (count_q < DEPTH_M1_C);

  // Next-state and datapath decisions of the fetch controller.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    squash_d   = squash_q;
    push_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_tgt_s;
        end else if (count_q < DEPTH_C) begin
          req_addr_d = fetch_pc_q;
          state_d    = S_REQ;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_REQ: begin
        if (Inst_Req_Ready) begin
          // A pending squash already holds the redirect target in fetch_pc.
          if (redirect_valid) begin
            fetch_pc_d = redirect_tgt_s;
          end else if (!squash_q) begin
            fetch_pc_d = req_addr_q + 32'd4;
          end else begin
            fetch_pc_d = fetch_pc_q;
          end
          if (squash_q || redirect_valid) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_RESP;
          end
        end else if (redirect_valid) begin
          // Request address must stay stable, so remember to drop its response.
          squash_d   = 1'b1;
          fetch_pc_d = redirect_tgt_s;
        end else begin
          state_d    = S_REQ;
        end
      end
      S_RESP: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_tgt_s;
          if (Inst_Valid) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (Inst_Valid) begin
          push_s = 1'b1;
          if (room_after_push_s) begin
            req_addr_d = fetch_pc_q;
            state_d    = S_REQ;
          end else begin
            state_d    = S_IDLE;
          end
        end else begin
          state_d = S_RESP;
        end
      end
      S_DRAIN: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_tgt_s;
        end else begin
          fetch_pc_d = fetch_pc_q;
        end
        if (Inst_Valid) begin
          squash_d = 1'b0;
          state_d  = S_IDLE;
        end else begin
          state_d  = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Fetch controller registers; handshake outputs are registered from next state.
  always_ff @(posedge cpu_clk) begin
    if (!cpu_reset) begin
      state_q      <= S_IDLE;
      fetch_pc_q   <= RESET_PC;
      req_addr_q   <= RESET_PC;
      squash_q     <= 1'b0;
      req_valid_q  <= 1'b0;
      resp_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_addr_q   <= req_addr_d;
      squash_q     <= squash_d;
      req_valid_q  <= (state_d == S_REQ);
      resp_ready_q <= (state_d == S_RESP) || (state_d == S_DRAIN);
    end
  end

  // Occupancy update: flush empties, simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    if (flush_s) begin
      count_d = CNT_W'(0);
    end else if (push_s && !pop_s) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_s && pop_s) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge cpu_clk) begin
    if (!cpu_reset) begin
      wptr_q  <= PTR_W'(0);
      rptr_q  <= PTR_W'(0);
      count_q <= CNT_W'(0);
    end else if (flush_s) begin
      wptr_q  <= PTR_W'(0);
      rptr_q  <= PTR_W'(0);
      count_q <= count_d;
    end else begin
      if (push_s) begin
        wptr_q <= wptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rptr_q <= rptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  // FIFO storage; contents need no reset because if_valid gates the head.
  always_ff @(posedge cpu_clk) begin
    if (push_s) begin
      mem_q[wptr_q] <= {req_addr_q, Instruction};
    end
  end

  assign head_s         = mem_q[rptr_q];
  assign PC             = req_addr_q;
  assign Inst_Req_Valid = req_valid_q;
  assign Inst_Ready     = resp_ready_q;
  assign fifo_count     = count_q;
  assign if_valid       = (count_q != CNT_W'(0));
  assign if_pc          = if_valid ? head_s[63:32] : 32'h0000_0000;
  assign if_inst        = if_valid ? head_s[31:0]  : 32'h0000_0000;

`ifdef FETCH_PERF_CNT_EN
  logic stall_s;
  assign stall_s = ((state_q == S_REQ)  && !Inst_Req_Ready) ||
                   ((state_q == S_RESP) && !Inst_Valid);

  // Free-running event counters; they wrap on overflow.
  always_ff @(posedge cpu_clk) begin
    if (!cpu_reset) begin
      perf_inst_cnt  <= 32'd0;
      perf_stall_cnt <= 32'd0;
      perf_flush_cnt <= 32'd0;
    end else begin
      if (push_s) begin
        perf_inst_cnt <= perf_inst_cnt + 32'd1;
      end
      if (stall_s) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (redirect_valid) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: transaction-level reference model
// (expected fetch PC, outstanding request/response, queue of buffered pairs),
// directed scenarios with literal expectations, then a randomized run.
`timescale 1ns/1ps
module tb_inst_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 4;

  logic        cpu_clk = 1'b0;
  logic        cpu_reset;
  logic [31:0] PC;
  logic        Inst_Req_Valid;
  logic        Inst_Req_Ready;
  logic [31:0] Instruction;
  logic        Inst_Valid;
  logic        Inst_Ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_ready;
  logic [2:0]  fifo_count;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_inst_cnt;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  always #5 cpu_clk = ~cpu_clk;

  inst_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .cpu_clk(cpu_clk), .cpu_reset(cpu_reset), .PC(PC),
    .Inst_Req_Valid(Inst_Req_Valid), .Inst_Req_Ready(Inst_Req_Ready),
    .Instruction(Instruction), .Inst_Valid(Inst_Valid), .Inst_Ready(Inst_Ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready),
    .fifo_count(fifo_count)
`ifdef FETCH_PERF_CNT_EN
    , .perf_inst_cnt(perf_inst_cnt), .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_fetch;
  logic [31:0] m_held_pc;
  logic [31:0] m_txn_pc;
  bit          m_req_pending;
  bit          m_resp_pending;
  bit          m_squash;
  logic [63:0] m_q[$];
  logic [31:0] hs_pcs[$];
  logic [31:0] pop_pcs[$];
  logic [31:0] m_perf_inst, m_perf_stall, m_perf_flush;
  int          delay_cnt;
  int          delay_knob;
  int          ready_mode;
  int          idle_gap;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fetch        = RST_PC;
    m_req_pending  = 1'b0;
    m_resp_pending = 1'b0;
    m_squash       = 1'b0;
    m_q.delete();
    m_perf_inst    = 32'd0;
    m_perf_stall   = 32'd0;
    m_perf_flush   = 32'd0;
    delay_cnt      = 0;
    idle_gap       = 0;
  endtask

  task automatic compare();
    logic [63:0] head;
    head = (m_q.size() > 0) ? m_q[0] : 64'd0;
    chk32("inst_ready", 32'(Inst_Ready), 32'(m_resp_pending));
    if (m_req_pending) begin
      chk32("req_valid_hold", 32'(Inst_Req_Valid), 32'd1);
      chk32("req_pc_hold", PC, m_held_pc);
    end else if (Inst_Req_Valid) begin
      chk32("req_pc", PC, m_fetch);
      chk32("req_slot_free", 32'(m_q.size() < DEPTH), 32'd1);
      chk32("req_while_resp", 32'(m_resp_pending), 32'd0);
    end
    chk32("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    chk32("if_valid", 32'(if_valid), 32'(m_q.size() > 0));
    chk32("if_pc", if_pc, head[63:32]);
    chk32("if_inst", if_inst, head[31:0]);
    if (!Inst_Req_Valid && !m_resp_pending && m_q.size() < DEPTH) idle_gap++;
    else idle_gap = 0;
    chk32("idle_bound", 32'(idle_gap <= 8), 32'd1);
`ifdef FETCH_PERF_CNT_EN
    chk32("perf_inst", perf_inst_cnt, m_perf_inst);
    chk32("perf_stall", perf_stall_cnt, m_perf_stall);
    chk32("perf_flush", perf_flush_cnt, m_perf_flush);
`endif
  endtask

  // One clock: environment drives, model advances, edge, then compare.
  task automatic tick();
    bit          rd, hs_req, hs_rsp, do_push;
    logic [31:0] tgt;
    logic [63:0] entry;
    case (ready_mode)
      0:       Inst_Req_Ready = 1'b1;
      1:       Inst_Req_Ready = 1'($urandom_range(0, 1));
      default: Inst_Req_Ready = 1'b0;
    endcase
    if (m_resp_pending && delay_cnt == 0) begin
      Inst_Valid  = 1'b1;
      Instruction = inst_of(m_txn_pc);
    end else begin
      Inst_Valid  = 1'b0;
      Instruction = $urandom;
      if (m_resp_pending) delay_cnt--;
    end
    if (cpu_reset) begin
      rd      = redirect_valid;
      tgt     = redirect_pc & 32'hFFFF_FFFC;
      hs_req  = Inst_Req_Valid && Inst_Req_Ready;
      hs_rsp  = Inst_Valid && Inst_Ready;
      do_push = hs_rsp && !m_squash && !rd;
      entry   = {m_txn_pc, Instruction};
      if ((Inst_Req_Valid && !Inst_Req_Ready) || (m_resp_pending && !m_squash && !Inst_Valid))
        m_perf_stall++;
      if (rd) m_perf_flush++;
      if (do_push) m_perf_inst++;
      if (hs_req) begin
        hs_pcs.push_back(PC);
        m_txn_pc = PC;
        if (!rd && !m_squash) m_fetch = PC + 32'd4;
        if (rd) m_squash = 1'b1;
        m_req_pending  = 1'b0;
        m_resp_pending = 1'b1;
        delay_cnt      = delay_knob;
      end else if (Inst_Req_Valid) begin
        m_req_pending = 1'b1;
        m_held_pc     = PC;
        if (rd) m_squash = 1'b1;
      end
      if (hs_rsp) begin
        m_resp_pending = 1'b0;
        m_squash       = 1'b0;
      end else if (m_resp_pending && rd) begin
        m_squash = 1'b1;
      end
      if (rd) m_fetch = tgt;
      if (rd) begin
        m_q.delete();
      end else begin
        if (if_ready && m_q.size() > 0) begin
          pop_pcs.push_back(m_q[0][63:32]);
          void'(m_q.pop_front());
        end
        if (do_push) m_q.push_back(entry);
      end
    end else begin
      model_reset();
    end
    @(posedge cpu_clk);
    @(negedge cpu_clk);
    if (cpu_reset) compare();
  endtask

  task automatic do_reset();
    cpu_reset      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    if_ready       = 1'b0;
    ready_mode     = 0;
    delay_knob     = 0;
    repeat (3) tick();
    chk32("rst_pc", PC, RST_PC);
    chk32("rst_req_valid", 32'(Inst_Req_Valid), 32'd0);
    chk32("rst_inst_ready", 32'(Inst_Ready), 32'd0);
    chk32("rst_if_valid", 32'(if_valid), 32'd0);
    chk32("rst_if_pc", if_pc, 32'd0);
    chk32("rst_if_inst", if_inst, 32'd0);
    chk32("rst_fifo_count", 32'(fifo_count), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk32("rst_perf_inst", perf_inst_cnt, 32'd0);
    chk32("rst_perf_stall", perf_stall_cnt, 32'd0);
    chk32("rst_perf_flush", perf_flush_cnt, 32'd0);
`endif
    cpu_reset = 1'b1;
    hs_pcs.delete();
    pop_pcs.delete();
  endtask

  task automatic test_stream();
    do_reset();
    if_ready = 1'b1;
    repeat (3) tick();
    chk32("t1_first_if_valid", 32'(if_valid), 32'd1);
    chk32("t1_first_if_pc", if_pc, 32'h0000_0000);
    chk32("t1_first_if_inst", if_inst, inst_of(32'h0000_0000));
    repeat (5) tick();
    chk32("t1_req0", qget(hs_pcs, 0), 32'h0000_0000);
    chk32("t1_req1", qget(hs_pcs, 1), 32'h0000_0004);
    chk32("t1_req2", qget(hs_pcs, 2), 32'h0000_0008);
    chk32("t1_pop1", qget(pop_pcs, 1), 32'h0000_0004);
  endtask

  task automatic test_full();
    do_reset();
    if_ready = 1'b0;
    repeat (20) tick();
    chk32("t2_full_count", 32'(fifo_count), 32'd4);
    chk32("t2_full_idle", 32'(Inst_Req_Valid), 32'd0);
    chk32("t2_full_reqs", 32'(hs_pcs.size()), 32'd4);
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
    repeat (10) tick();
    chk32("t2_refill_reqs", 32'(hs_pcs.size()), 32'd5);
    chk32("t2_refill_pc", qget(hs_pcs, 4), 32'h0000_0010);
    chk32("t2_refill_count", 32'(fifo_count), 32'd4);
  endtask

  task automatic test_stall();
    do_reset();
    if_ready   = 1'b1;
    ready_mode = 2;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk32("t3_stall_pc", PC, 32'h0000_0000);
      chk32("t3_stall_valid", 32'(Inst_Req_Valid), 32'd1);
    end
`ifdef FETCH_PERF_CNT_EN
    chk32("t3_perf_stall", perf_stall_cnt, 32'd5);
`endif
    ready_mode = 0;
    repeat (4) tick();
    chk32("t3_after_stall", qget(hs_pcs, 0), 32'h0000_0000);
  endtask

  task automatic test_redirect_resp();
    bit seen;
    do_reset();
    if_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (fifo_count == 3'd2) seen = 1'b1;
    end
    chk32("t4_fill_two", 32'(seen), 32'd1);
    delay_knob = 5;
    tick();
    chk32("t4_in_resp", 32'(Inst_Ready), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    delay_knob     = 0;
    chk32("t4_flushed_count", 32'(fifo_count), 32'd0);
    chk32("t4_flushed_valid", 32'(if_valid), 32'd0);
    if_ready = 1'b1;
    repeat (15) tick();
    chk32("t4_next_req", qget(hs_pcs, 3), 32'h0000_0100);
    chk32("t4_first_pop", qget(pop_pcs, 0), 32'h0000_0100);
  endtask

  task automatic test_redirect_req(input logic [31:0] tgt, input string tag);
    do_reset();
    if_ready   = 1'b1;
    ready_mode = 2;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk32({tag, "_held_pc"}, PC, 32'h0000_0000);
    end
    ready_mode = 0;
    repeat (12) tick();
    chk32({tag, "_old_req"}, qget(hs_pcs, 0), 32'h0000_0000);
    chk32({tag, "_new_req"}, qget(hs_pcs, 1), tgt & 32'hFFFF_FFFC);
    chk32({tag, "_next_req"}, qget(hs_pcs, 2), (tgt & 32'hFFFF_FFFC) + 32'd4);
    chk32({tag, "_first_pop"}, qget(pop_pcs, 0), tgt & 32'hFFFF_FFFC);
  endtask

  task automatic test_random();
    int ready_pct;
    do_reset();
    ready_mode = 1;
    ready_pct  = 50;
    for (int i = 0; i < 4000; i++) begin
      if (i % 256 == 0) ready_pct = (i / 256 % 3 == 0) ? 10 : ((i / 256 % 3 == 1) ? 50 : 95);
      delay_knob     = $urandom_range(0, 3);
      if_ready       = ($urandom_range(0, 99) < ready_pct);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : $urandom;
      tick();
    end
    redirect_valid = 1'b0;
    chk32("rand_progress", 32'(pop_pcs.size() > 200), 32'd1);
  endtask

  initial begin
    cpu_reset      = 1'b0;
    Inst_Req_Ready = 1'b0;
    Inst_Valid     = 1'b0;
    Instruction    = 32'd0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    if_ready       = 1'b0;
    ready_mode     = 0;
    delay_knob     = 0;
    model_reset();
    @(negedge cpu_clk);
    test_stream();
    test_full();
    test_stall();
    test_redirect_resp();
    test_redirect_req(32'h0000_0203, "t5");
    test_redirect_req(32'hFFFF_FFFC, "t6");
    chk32("t6_wrap", qget(hs_pcs, 2), 32'h0000_0000);
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
